// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and helpers for the register-file write-back scheduler.
package regfile_wb_arbiter_pkg;

    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned TAG_W     = 3;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] regAddr;
        logic [RF_DATA_W-1:0] data;
        logic [TAG_W-1:0]     tag;
    } wb_entry_t;

    // True when tagA was issued before tagB; the tag space is twice the max outstanding count.
    function automatic logic tagOlder(input logic [TAG_W-1:0] tagA, input logic [TAG_W-1:0] tagB);
        logic [TAG_W-1:0] diff;
        diff = TAG_W'(tagB - tagA);
        return (diff != '0) && (diff <= TAG_W'(4));
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Request, register-file write port and decode scoreboard signals of the write-back scheduler.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W
);
    logic              src0_valid;
    logic              src0_ready;
    logic [ADDR_W-1:0] src0_reg;
    logic [DATA_W-1:0] src0_data;
    logic              src1_valid;
    logic              src1_ready;
    logic [ADDR_W-1:0] src1_reg;
    logic [DATA_W-1:0] src1_data;
    logic              regWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              rs_busy;
    logic              rt_busy;
    logic              idle;

    modport slave (
        input  src0_valid, src0_reg, src0_data,
        input  src1_valid, src1_reg, src1_data,
        input  rs, rt,
        output src0_ready, src1_ready,
        output regWrite, writeReg, writeData,
        output rs_busy, rt_busy, idle
    );

    modport master (
        output src0_valid, src0_reg, src0_data,
        output src1_valid, src1_reg, src1_data,
        output rs, rt,
        input  src0_ready, src1_ready,
        input  regWrite, writeReg, writeData,
        input  rs_busy, rt_busy, idle
    );
endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Per-source write-back FIFO; exposes every slot's address/valid so decode can see pending writes.
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pushValid,
    input  wb_entry_t                       pushEntry,
    input  logic                            pop,
    output wb_entry_t                       head,
    output logic                            headValid,
    output logic                            full,
    output logic [DEPTH-1:0][RF_ADDR_W-1:0] entryAddr,
    output logic [DEPTH-1:0]                entryValid
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W:0]   wrPtr;
    logic [PTR_W:0]   rdPtr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             doPop;

    // Extra MSB distinguishes full from empty when the low bits match.
    assign full      = (wrPtr[PTR_W] != rdPtr[PTR_W]) && (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
    assign headValid = (wrPtr != rdPtr);
    assign push      = pushValid && !full;
    assign doPop     = pop && headValid;
    assign head      = mem[rdPtr[PTR_W-1:0]];
    assign count     = wrPtr - rdPtr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + (PTR_W+1)'(1);
            if (doPop) rdPtr <= rdPtr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr[PTR_W-1:0]] <= pushEntry;
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset     = '0;
        entryAddr  = '0;
        entryValid = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            offset        = PTR_W'(PTR_W'(i) - rdPtr[PTR_W-1:0]);
            entryValid[i] = ((PTR_W+1)'(offset) < count);
            entryAddr[i]  = mem[i].regAddr;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load write-back with age-aware round-robin
// arbitration, and reports in-flight writes to decode.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_arbiter_if.slave bus
);
    wb_entry_t                       pushEntry0;
    wb_entry_t                       pushEntry1;
    wb_entry_t                       head0;
    wb_entry_t                       head1;
    wb_entry_t                       grantEntry;
    logic                            headValid0;
    logic                            headValid1;
    logic                            full0;
    logic                            full1;
    logic                            accept0;
    logic                            accept1;
    logic                            pop0;
    logic                            pop1;
    logic                            anyPop;
    logic                            grant1;
    logic                            rrPtr;
    logic [TAG_W-1:0]                tagCnt;
    logic [DEPTH-1:0][RF_ADDR_W-1:0] addrs0;
    logic [DEPTH-1:0][RF_ADDR_W-1:0] addrs1;
    logic [DEPTH-1:0]                valids0;
    logic [DEPTH-1:0]                valids1;
    logic                            rsHit;
    logic                            rtHit;

    assign accept0        = bus.src0_valid && !full0;
    assign accept1        = bus.src1_valid && !full1;
    assign bus.src0_ready = !full0;
    assign bus.src1_ready = !full1;

    // src0 takes the older tag when both sources are accepted together.
    always_comb begin
        pushEntry0 = '{regAddr: RF_ADDR_W'(bus.src0_reg), data: RF_DATA_W'(bus.src0_data), tag: tagCnt};
        pushEntry1 = '{regAddr: RF_ADDR_W'(bus.src1_reg), data: RF_DATA_W'(bus.src1_data),
                       tag: accept0 ? TAG_W'(tagCnt + TAG_W'(1)) : tagCnt};
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk        (clk),
        .rst        (rst),
        .pushValid  (bus.src0_valid),
        .pushEntry  (pushEntry0),
        .pop        (pop0),
        .head       (head0),
        .headValid  (headValid0),
        .full       (full0),
        .entryAddr  (addrs0),
        .entryValid (valids0)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk        (clk),
        .rst        (rst),
        .pushValid  (bus.src1_valid),
        .pushEntry  (pushEntry1),
        .pop        (pop1),
        .head       (head1),
        .headValid  (headValid1),
        .full       (full1),
        .entryAddr  (addrs1),
        .entryValid (valids1)
    );

    // Same-register heads must commit in issue order; otherwise alternate.
    always_comb begin
        grant1 = 1'b0;
        if (headValid0 && headValid1) begin
            if (head0.regAddr == head1.regAddr) grant1 = tagOlder(head1.tag, head0.tag);
            else                                grant1 = rrPtr;
        end else begin
            grant1 = headValid1;
        end
        anyPop     = headValid0 || headValid1;
        pop0       = anyPop && !grant1;
        pop1       = anyPop && grant1;
        grantEntry = grant1 ? head1 : head0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tagCnt        <= '0;
            rrPtr         <= 1'b0;
            bus.regWrite  <= 1'b0;
            bus.writeReg  <= '0;
            bus.writeData <= '0;
        end else begin
            tagCnt        <= TAG_W'(tagCnt + TAG_W'(accept0) + TAG_W'(accept1));
            if (anyPop) rrPtr <= !grant1;
            bus.regWrite  <= anyPop;
            bus.writeReg  <= anyPop ? ADDR_W'(grantEntry.regAddr) : '0;
            bus.writeData <= anyPop ? DATA_W'(grantEntry.data) : '0;
        end
    end

    // Pending writes live either in a FIFO slot or in the output stage.
    always_comb begin
        rsHit = bus.regWrite && (bus.writeReg == bus.rs);
        rtHit = bus.regWrite && (bus.writeReg == bus.rt);
        for (int i = 0; i < int'(DEPTH); i++) begin
            rsHit = rsHit || (valids0[i] && (addrs0[i] == RF_ADDR_W'(bus.rs)))
                          || (valids1[i] && (addrs1[i] == RF_ADDR_W'(bus.rs)));
            rtHit = rtHit || (valids0[i] && (addrs0[i] == RF_ADDR_W'(bus.rt)))
                          || (valids1[i] && (addrs1[i] == RF_ADDR_W'(bus.rt)));
        end
    end

    assign bus.rs_busy = rsHit;
    assign bus.rt_busy = rtHit;
    assign bus.idle    = !headValid0 && !headValid1 && !bus.regWrite;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: commit order, busy timing, backpressure and reset discard.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vecCount  = 0;
    int   missCount = 0;
    int   cyc       = 0;
    int   stall1    = 0;

    req_t        q0[$];
    req_t        q1[$];
    logic [63:0] commits[$];
    int          commitCyc[$];
    logic [63:0] expQ[$];

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A write is committed when regWrite is high going into the capturing edge.
    always @(negedge clk) begin
        if (rst && bus.regWrite) begin
            commits.push_back({27'd0, bus.writeReg, bus.writeData});
            commitCyc.push_back(cyc);
        end
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] packW(input int r, input int d);
        return {27'd0, 5'(r), 32'(d)};
    endfunction

    task automatic idleInputs();
        bus.src0_valid = 1'b0;
        bus.src1_valid = 1'b0;
        bus.src0_reg   = '0;
        bus.src1_reg   = '0;
        bus.src0_data  = '0;
        bus.src1_data  = '0;
    endtask

    task automatic resetDut();
        @(negedge clk);
        idleInputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        commits.delete();
        commitCyc.delete();
    endtask

    task automatic addReq(input int src, input int r, input int d);
        req_t x;
        x.addr = 5'(r);
        x.data = 32'(d);
        if (src == 0) q0.push_back(x);
        else          q1.push_back(x);
    endtask

    // Drives both queues with valid/ready handshakes until drained and the block is idle.
    task automatic runTraffic();
        bit   d0 = 0, d1 = 0, r0 = 0, r1 = 0;
        int   n = 0;
        req_t tmp;
        stall1 = 0;
        while (n < 200) begin
            @(negedge clk);
            if (d0 && r0) tmp = q0.pop_front();
            if (d1 && r1) tmp = q1.pop_front();
            d0 = (q0.size() > 0);
            d1 = (q1.size() > 0);
            bus.src0_valid = d0;
            bus.src1_valid = d1;
            if (d0) begin bus.src0_reg = q0[0].addr; bus.src0_data = q0[0].data; end
            if (d1) begin bus.src1_reg = q1[0].addr; bus.src1_data = q1[0].data; end
            r0 = bus.src0_ready;
            r1 = bus.src1_ready;
            if (d1 && !r1) stall1++;
            if (!d0 && !d1 && bus.idle) break;
            n++;
        end
        idleInputs();
        checkVal("drain_in_budget", 64'(n < 200), 64'd1);
    endtask

    task automatic checkCommits(input string tag);
        checkVal({tag, "_count"}, 64'(commits.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < commits.size(); i++)
            checkVal($sformatf("%s_%0d", tag, i), commits[i], expQ[i]);
    endtask

    task automatic checkGapless(input string tag);
        if (commits.size() == 0) checkVal(tag, 64'd0, 64'd1);
        else checkVal(tag, 64'(commitCyc[$] - commitCyc[0]), 64'(commits.size() - 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idleInputs();
        bus.rs = '0;
        bus.rt = '0;
        #1;
        checkVal("rst_regWrite", 64'(bus.regWrite), 64'd0);
        checkVal("rst_ready0",   64'(bus.src0_ready), 64'd1);
        checkVal("rst_ready1",   64'(bus.src1_ready), 64'd1);
        checkVal("rst_idle",     64'(bus.idle), 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Single write r21 = 45 and its busy window.
        bus.rs = 5'd21;
        @(negedge clk);
        checkVal("sw_busy_pre", 64'(bus.rs_busy), 64'd0);
        bus.src0_valid = 1'b1; bus.src0_reg = 5'd21; bus.src0_data = 32'd45;
        @(negedge clk);
        bus.src0_valid = 1'b0;
        checkVal("sw_busy_k",    64'(bus.rs_busy), 64'd1);
        checkVal("sw_rt_free",   64'(bus.rt_busy), 64'd0);
        checkVal("sw_wr_k",      64'(bus.regWrite), 64'd0);
        @(negedge clk);
        checkVal("sw_wr_k1",     64'(bus.regWrite), 64'd1);
        checkVal("sw_reg_k1",    64'(bus.writeReg), 64'd21);
        checkVal("sw_data_k1",   64'(bus.writeData), 64'd45);
        checkVal("sw_busy_k1",   64'(bus.rs_busy), 64'd1);
        @(negedge clk);
        checkVal("sw_busy_k2",   64'(bus.rs_busy), 64'd0);
        checkVal("sw_wr_k2",     64'(bus.regWrite), 64'd0);
        checkVal("sw_idle_k2",   64'(bus.idle), 64'd1);

        // Round-robin on distinct registers.
        resetDut();
        for (int i = 0; i < 4; i++) begin
            addReq(0, 1 + i, 101 + i);
            addReq(1, 5 + i, 105 + i);
        end
        runTraffic();
        expQ.delete();
        for (int i = 0; i < 4; i++) begin
            expQ.push_back(packW(1 + i, 101 + i));
            expQ.push_back(packW(5 + i, 105 + i));
        end
        checkCommits("rr");
        checkGapless("rr_gapless");

        // Same register from both sources on consecutive edges.
        commits.delete(); commitCyc.delete();
        @(negedge clk);
        bus.src1_valid = 1'b1; bus.src1_reg = 5'd23; bus.src1_data = 32'd10;
        @(negedge clk);
        bus.src1_valid = 1'b0;
        bus.src0_valid = 1'b1; bus.src0_reg = 5'd23; bus.src0_data = 32'd75;
        @(negedge clk);
        bus.src0_valid = 1'b0;
        repeat (4) @(negedge clk);
        expQ.delete();
        expQ.push_back(packW(23, 10));
        expQ.push_back(packW(23, 75));
        checkCommits("samereg");

        // Seven src0 writes bring the tag counter to 7, then a same-edge tie to r5 wraps the tag.
        resetDut();
        for (int i = 0; i < 7; i++) addReq(0, 10 + i, 200 + i);
        runTraffic();
        expQ.delete();
        for (int i = 0; i < 7; i++) expQ.push_back(packW(10 + i, 200 + i));
        checkCommits("solo");
        checkGapless("solo_gapless");
        commits.delete(); commitCyc.delete();
        addReq(0, 5, 1);
        addReq(1, 5, 2);
        runTraffic();
        expQ.delete();
        expQ.push_back(packW(5, 1));
        expQ.push_back(packW(5, 2));
        checkCommits("tie_wrap");

        // Both sources saturating; src1 must see backpressure and nothing is lost.
        resetDut();
        for (int i = 0; i < 6; i++) addReq(0, 1 + i, 300 + i);
        for (int i = 0; i < 4; i++) addReq(1, 20 + i, 400 + i);
        runTraffic();
        expQ.delete();
        for (int i = 0; i < 4; i++) begin
            expQ.push_back(packW(1 + i, 300 + i));
            expQ.push_back(packW(20 + i, 400 + i));
        end
        expQ.push_back(packW(5, 304));
        expQ.push_back(packW(6, 305));
        checkCommits("bp");
        checkVal("bp_src1_stalled", 64'(stall1 > 0), 64'd1);

        // Reset with three writes in flight discards all of them.
        commits.delete(); commitCyc.delete();
        @(negedge clk);
        bus.src0_valid = 1'b1; bus.src0_reg = 5'd1; bus.src0_data = 32'd1;
        bus.src1_valid = 1'b1; bus.src1_reg = 5'd2; bus.src1_data = 32'd2;
        @(negedge clk);
        bus.src1_valid = 1'b0;
        bus.src0_reg = 5'd3; bus.src0_data = 32'd3;
        @(posedge clk);
        #1;
        bus.src0_valid = 1'b0;
        checkVal("rst_pre_wr", 64'(bus.regWrite), 64'd1);
        rst = 1'b0;
        #1;
        checkVal("rst_mid_wr",    64'(bus.regWrite), 64'd0);
        checkVal("rst_mid_reg",   64'(bus.writeReg), 64'd0);
        checkVal("rst_mid_data",  64'(bus.writeData), 64'd0);
        checkVal("rst_mid_rdy0",  64'(bus.src0_ready), 64'd1);
        checkVal("rst_mid_rdy1",  64'(bus.src1_ready), 64'd1);
        checkVal("rst_mid_idle",  64'(bus.idle), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        checkVal("rst_no_commit", 64'(commits.size()), 64'd0);
        checkVal("rst_post_idle", 64'(bus.idle), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
